// File: rtl/gf180mcu_fd_io__bank_seq.sv
// gf180mcu_fd_io__bank_seq
// Staggered enable sequencer for the IO ring pad banks. Once the ring supply
// reports good and an enable is requested, the per-bank input/output enables
// are raised one control at a time (IE before OE within a bank, bank 0 first),
// with GAP cycles between changes, to bound simultaneous-switching current.
// Turn-off walks the same controls back in exact reverse order. Loss of the
// synchronized supply-good collapses every control on the next edge.
//
// Ports:
//   CLK       sole clock, all state on the rising edge
//   RST       synchronous, active-high reset
//   PWR_OK    ring-supply-good (asynchronous, 2-flop synchronized internally)
//   EN_REQ    level request to sequence banks on
//   DIS_REQ   level request to sequence banks off (wins over EN_REQ)
//   IE_EN     per-bank input-enable  (registered)
//   OE_EN     per-bank output-enable (registered)
//   READY     all banks fully enabled
//   BUSY      settle / ramp-up / ramp-down in progress
//   PWR_FAIL  sticky: supply lost while any control was set or BUSY was high
module gf180mcu_fd_io__bank_seq #(
  parameter int NBANK  = 4,
  parameter int SETTLE = 8,
  parameter int GAP    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWR_OK,
  input  logic             EN_REQ,
  input  logic             DIS_REQ,
  output logic [NBANK-1:0] IE_EN,
  output logic [NBANK-1:0] OE_EN,
  output logic             READY,
  output logic             BUSY,
  output logic             PWR_FAIL
);

  // Control vector is interleaved: bit 2i = IE of bank i, bit 2i+1 = OE of bank i.
  localparam int CW    = 2 * NBANK;
  localparam int CMAX  = (SETTLE > GAP) ? SETTLE : GAP;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CW-1:0]    C_ZERO    = {CW{1'b0}};

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_UP     = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    c_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             busy_r;
  logic             pwr_fail_r;
  logic             pok_meta_r;
  logic             pok_sync_r;   // synchronized supply-good (pok_s)

  logic             cnt_zero_s;
  logic             c_full_s;
  logic             c_any_s;
  logic [CW-1:0]    c_up_s;
  logic [CW-1:0]    c_dn_s;

  // Set the lowest clear bit: adding one carries through the trailing ones
  // and lands on the first zero, which the OR then keeps.
  function automatic logic [CW-1:0] set_lowest_clear(input logic [CW-1:0] v);
    return v | (v + CW'(1));
  endfunction

  // Clear the highest set bit, scanning from the top.
  function automatic logic [CW-1:0] clr_highest_set(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          found;
    r     = v;
    found = 1'b0;
    for (int i = CW - 1; i >= 0; i--) begin
      r[i]  = (!found && v[i]) ? 1'b0 : r[i];
      found = found | v[i];
    end
    return r;
  endfunction

  assign cnt_zero_s = (cnt_r == CNT_ZERO);
  assign c_full_s   = &c_r;
  assign c_any_s    = |c_r;
  assign c_up_s     = set_lowest_clear(c_r);
  assign c_dn_s     = clr_highest_set(c_r);

  // Two-flop synchronizer for the asynchronous supply-good input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pok_meta_r <= 1'b0;
      pok_sync_r <= 1'b0;
    end else begin
      pok_meta_r <= PWR_OK;
      pok_sync_r <= pok_meta_r;
    end
  end

  // Sequencer FSM: supply loss overrides everything, then DIS_REQ beats EN_REQ.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_OFF;
      c_r        <= C_ZERO;
      cnt_r      <= CNT_ZERO;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      pwr_fail_r <= 1'b0;
    end else if (!pok_sync_r) begin
      // Failure is only flagged if something was actually powered or moving.
      pwr_fail_r <= pwr_fail_r | c_any_s | busy_r;
      state_r    <= ST_OFF;
      c_r        <= C_ZERO;
      cnt_r      <= CNT_ZERO;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (EN_REQ && !DIS_REQ) begin
            state_r    <= ST_SETTLE;
            cnt_r      <= SETTLE_LD;
            busy_r     <= 1'b1;
            pwr_fail_r <= 1'b0;
          end else begin
            state_r <= ST_OFF;
            c_r     <= C_ZERO;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (DIS_REQ) begin
            state_r <= ST_OFF;
            busy_r  <= 1'b0;
          end else if (cnt_zero_s) begin
            state_r <= ST_UP;
            c_r     <= c_up_s;
            cnt_r   <= GAP_LD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_UP: begin
          if (DIS_REQ) begin
            // DOWN entry: first control drops on this very edge.
            state_r <= ST_DOWN;
            c_r     <= c_dn_s;
            cnt_r   <= GAP_LD;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else if (cnt_zero_s) begin
            if (c_full_s) begin
              state_r <= ST_ON;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              c_r   <= c_up_s;
              cnt_r <= GAP_LD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_ON: begin
          if (DIS_REQ) begin
            state_r <= ST_DOWN;
            c_r     <= c_dn_s;
            cnt_r   <= GAP_LD;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_ON;
          end
        end
        ST_DOWN: begin
          // Requests are ignored until the ramp-down completes.
          if (cnt_zero_s) begin
            if (c_any_s) begin
              c_r   <= c_dn_s;
              cnt_r <= GAP_LD;
            end else begin
              state_r <= ST_OFF;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_OFF;
          c_r     <= C_ZERO;
          cnt_r   <= CNT_ZERO;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // De-interleave the control register onto the per-bank outputs.
  for (genvar i = 0; i < NBANK; i++) begin : g_out
    assign IE_EN[i] = c_r[2*i];
    assign OE_EN[i] = c_r[2*i+1];
  end

  assign READY    = ready_r;
  assign BUSY     = busy_r;
  assign PWR_FAIL = pwr_fail_r;

endmodule

// File: tb/tb_gf180mcu_fd_io__bank_seq.sv
// Self-checking bench for gf180mcu_fd_io__bank_seq: a default-parameter
// instance checked against a deadline-based reference model every cycle, plus
// table-driven and hand-written timing checks, and a NBANK=1/SETTLE=1/GAP=1
// instance checked with hand-written sequences.
module tb_gf180mcu_fd_io__bank_seq;

  localparam int P_N = 4;
  localparam int P_S = 8;
  localparam int P_G = 16;

  logic       CLK;
  logic       RST;
  logic       PWR_OK;
  logic       EN_REQ;
  logic       DIS_REQ;
  logic [3:0] IE_EN;
  logic [3:0] OE_EN;
  logic       READY;
  logic       BUSY;
  logic       PWR_FAIL;
  logic [0:0] s_ie;
  logic [0:0] s_oe;
  logic       s_ready;
  logic       s_busy;
  logic       s_pfail;

  gf180mcu_fd_io__bank_seq #(.NBANK(P_N), .SETTLE(P_S), .GAP(P_G)) u_dut (
    .CLK(CLK), .RST(RST), .PWR_OK(PWR_OK), .EN_REQ(EN_REQ), .DIS_REQ(DIS_REQ),
    .IE_EN(IE_EN), .OE_EN(OE_EN), .READY(READY), .BUSY(BUSY), .PWR_FAIL(PWR_FAIL)
  );

  gf180mcu_fd_io__bank_seq #(.NBANK(1), .SETTLE(1), .GAP(1)) u_small (
    .CLK(CLK), .RST(RST), .PWR_OK(PWR_OK), .EN_REQ(EN_REQ), .DIS_REQ(DIS_REQ),
    .IE_EN(s_ie), .OE_EN(s_oe), .READY(s_ready), .BUSY(s_busy), .PWR_FAIL(s_pfail)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges, holds the number of controls on and the
  // absolute edge number of the next scheduled change.
  int   cyc      = 0;
  int   m_mode   = 0;   // 0 off, 1 settle, 2 up, 3 on, 4 down
  int   m_nset   = 0;
  int   m_tevt   = 0;
  logic m_pfail  = 1'b0;
  logic pk0      = 1'b0;
  logic pk1      = 1'b0;

  task automatic model_step();
    logic pok_s;
    logic was_busy;
    cyc++;
    pok_s    = pk1;
    was_busy = (m_mode == 1) || (m_mode == 2) || (m_mode == 4);
    if (RST) begin
      pk0 = 1'b0; pk1 = 1'b0;
      m_mode = 0; m_nset = 0; m_pfail = 1'b0;
    end else begin
      pk1 = pk0;
      pk0 = PWR_OK;
      if (!pok_s) begin
        if (m_nset != 0 || was_busy) m_pfail = 1'b1;
        m_mode = 0; m_nset = 0;
      end else begin
        case (m_mode)
          0: if (EN_REQ && !DIS_REQ) begin
               m_mode = 1; m_tevt = cyc + P_S; m_pfail = 1'b0;
             end
          1: if (DIS_REQ) m_mode = 0;
             else if (cyc == m_tevt) begin m_mode = 2; m_nset = 1; m_tevt = cyc + P_G; end
          2: if (DIS_REQ) begin m_mode = 4; m_nset--; m_tevt = cyc + P_G; end
             else if (cyc == m_tevt) begin
               if (m_nset < 2 * P_N) begin m_nset++; m_tevt = cyc + P_G; end
               else m_mode = 3;
             end
          3: if (DIS_REQ) begin m_mode = 4; m_nset--; m_tevt = cyc + P_G; end
          4: if (cyc == m_tevt) begin
               if (m_nset > 0) begin m_nset--; m_tevt = cyc + P_G; end
               else m_mode = 0;
             end
          default: m_mode = 0;
        endcase
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] c;
    logic [3:0] eie;
    logic [3:0] eoe;
    c = 8'((1 << m_nset) - 1);
    for (int i = 0; i < P_N; i++) begin
      eie[i] = c[2*i];
      eoe[i] = c[2*i+1];
    end
    chk("model", {21'd0, IE_EN, OE_EN, READY, BUSY, PWR_FAIL},
        {21'd0, eie, eoe, (m_mode == 3), (m_mode == 1 || m_mode == 2 || m_mode == 4), m_pfail});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model();
  endtask

  typedef struct {
    int         off;
    logic [3:0] ie;
    logic [3:0] oe;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int   last_chg;
    int   nchg;
    logic [7:0] prev;
    logic ready_seen;

    tbl[0]  = '{0,   4'h0, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{7,   4'h0, 4'h0, 1'b0, 1'b1};
    tbl[2]  = '{8,   4'h1, 4'h0, 1'b0, 1'b1};
    tbl[3]  = '{23,  4'h1, 4'h0, 1'b0, 1'b1};
    tbl[4]  = '{24,  4'h1, 4'h1, 1'b0, 1'b1};
    tbl[5]  = '{39,  4'h1, 4'h1, 1'b0, 1'b1};
    tbl[6]  = '{40,  4'h3, 4'h1, 1'b0, 1'b1};
    tbl[7]  = '{56,  4'h3, 4'h3, 1'b0, 1'b1};
    tbl[8]  = '{72,  4'h7, 4'h3, 1'b0, 1'b1};
    tbl[9]  = '{104, 4'hF, 4'h7, 1'b0, 1'b1};
    tbl[10] = '{119, 4'hF, 4'h7, 1'b0, 1'b1};
    tbl[11] = '{120, 4'hF, 4'hF, 1'b0, 1'b1};
    tbl[12] = '{135, 4'hF, 4'hF, 1'b0, 1'b1};
    tbl[13] = '{136, 4'hF, 4'hF, 1'b1, 1'b0};

    RST = 1'b1; PWR_OK = 1'b0; EN_REQ = 1'b0; DIS_REQ = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {IE_EN, OE_EN, READY, BUSY, PWR_FAIL}, 11'd0);
    RST = 1'b0;

    // Power up, enable, walk the table.
    PWR_OK = 1'b1;
    repeat (3) tick();
    chk("idle_off", {28'd0, BUSY, READY, IE_EN[0], OE_EN[0]}, 32'd0);
    EN_REQ = 1'b1;
    tick();
    EN_REQ = 1'b0;
    last_chg = 0; nchg = 0; prev = {IE_EN, OE_EN};
    for (int off = 0; off <= 136; off++) begin
      if (off > 0) tick();
      for (int k = 0; k < 14; k++) begin
        if (tbl[k].off == off) begin
          chk($sformatf("up_ie@%0d", off), IE_EN, tbl[k].ie);
          chk($sformatf("up_oe@%0d", off), OE_EN, tbl[k].oe);
          chk($sformatf("up_rdy_busy@%0d", off), {READY, BUSY}, {tbl[k].ready, tbl[k].busy});
        end
      end
      if ({IE_EN, OE_EN} != prev) begin
        chk($sformatf("spacing#%0d", nchg), off - last_chg, (nchg == 0) ? P_S : P_G);
        last_chg = off; nchg++; prev = {IE_EN, OE_EN};
      end
    end
    chk("num_changes_up", nchg, 8);

    // Ramp down from ON.
    DIS_REQ = 1'b1;
    tick();
    chk("dn_entry", {READY, BUSY, OE_EN, IE_EN}, {1'b0, 1'b1, 4'h7, 4'hF});
    for (int off = 1; off <= 128; off++) begin
      tick();
      if (off == 111) chk("dn_ie0_held", {IE_EN, OE_EN}, 8'h10);
      if (off == 112) chk("dn_ie0_clr", {IE_EN, OE_EN, BUSY}, 9'h001);
      if (off == 127) chk("dn_busy_held", BUSY, 1'b1);
      if (off == 128) chk("dn_off", {BUSY, READY}, 2'b00);
    end
    DIS_REQ = 1'b0;

    // Abort during ramp-up at E0+30.
    EN_REQ = 1'b1; tick(); EN_REQ = 1'b0;
    ready_seen = 1'b0;
    for (int off = 1; off <= 29; off++) begin tick(); ready_seen |= READY; end
    chk("abort_pre", {IE_EN, OE_EN}, 8'h11);
    DIS_REQ = 1'b1; tick(); DIS_REQ = 1'b0;
    chk("abort_entry", {IE_EN, OE_EN, BUSY}, {4'h1, 4'h0, 1'b1});
    for (int off = 31; off <= 62; off++) begin
      tick(); ready_seen |= READY;
      if (off == 45) chk("abort_ie_held", IE_EN, 4'h1);
      if (off == 46) chk("abort_ie_clr", {IE_EN, OE_EN}, 8'h00);
      if (off == 61) chk("abort_busy_held", BUSY, 1'b1);
      if (off == 62) chk("abort_off", BUSY, 1'b0);
    end
    chk("abort_no_ready", ready_seen, 1'b0);

    // Supply loss mid ramp-up.
    EN_REQ = 1'b1; tick(); EN_REQ = 1'b0;
    repeat (50) tick();
    PWR_OK = 1'b0;
    tick(); chk("pok_edge1", {IE_EN, OE_EN}, 8'h31);
    tick(); chk("pok_edge2", {IE_EN, OE_EN}, 8'h31);
    tick(); chk("pok_edge3", {IE_EN, OE_EN, READY, BUSY, PWR_FAIL}, 11'h001);
    EN_REQ = 1'b1;
    repeat (4) tick();
    chk("en_while_nopok", {BUSY, PWR_FAIL}, 2'b01);
    PWR_OK = 1'b1;
    tick(); tick();
    chk("pok_resync", {BUSY, PWR_FAIL}, 2'b01);
    tick();
    chk("pfail_cleared", {BUSY, PWR_FAIL}, 2'b10);
    EN_REQ = 1'b0;
    DIS_REQ = 1'b1; tick(); tick(); DIS_REQ = 1'b0;
    chk("settle_abort", BUSY, 1'b0);

    // EN and DIS together: no start in OFF, ramp-down in ON.
    EN_REQ = 1'b1; DIS_REQ = 1'b1;
    repeat (3) tick();
    chk("both_off", {BUSY, IE_EN}, 5'd0);
    DIS_REQ = 1'b0; tick(); EN_REQ = 1'b0;
    repeat (136) tick();
    chk("reach_on", {READY, BUSY}, 2'b10);
    EN_REQ = 1'b1; DIS_REQ = 1'b1; tick();
    chk("both_on", {READY, BUSY, OE_EN[3]}, 3'b010);
    repeat (128) tick();
    chk("both_on_off", BUSY, 1'b0);
    EN_REQ = 1'b0; DIS_REQ = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RST     = ($urandom_range(1499, 0) == 0);
      PWR_OK  = PWR_OK ? ($urandom_range(399, 0) != 0) : ($urandom_range(7, 0) == 0);
      EN_REQ  = ($urandom_range(19, 0) == 0);
      DIS_REQ = ($urandom_range(249, 0) == 0);
      tick();
    end

    // Minimal-parameter instance.
    RST = 1'b1; PWR_OK = 1'b1; EN_REQ = 1'b0; DIS_REQ = 1'b0;
    tick(); RST = 1'b0;
    chk("s_reset", {s_ie, s_oe, s_ready, s_busy, s_pfail}, 5'd0);
    tick(); tick();
    EN_REQ = 1'b1; tick(); EN_REQ = 1'b0;
    chk("s_e0", {s_ie, s_oe, s_ready, s_busy}, 4'b0001);
    tick(); chk("s_e1", {s_ie, s_oe, s_ready, s_busy}, 4'b1001);
    tick(); chk("s_e2", {s_ie, s_oe, s_ready, s_busy}, 4'b1101);
    tick(); chk("s_e3", {s_ie, s_oe, s_ready, s_busy}, 4'b1110);
    DIS_REQ = 1'b1; tick(); DIS_REQ = 1'b0;
    chk("s_d0", {s_ie, s_oe, s_ready, s_busy}, 4'b1001);
    tick(); chk("s_d1", {s_ie, s_oe, s_busy}, 3'b001);
    tick(); chk("s_d2", s_busy, 1'b0);
    EN_REQ = 1'b1; tick(); EN_REQ = 1'b0;
    tick(); chk("s_mid_up", {s_ie, s_oe, s_busy}, 3'b101);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("s_rst_mid_up", {s_ie, s_oe, s_ready, s_busy, s_pfail}, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
